// File: rtl/dpram_hs_pkg.sv
// =============================================================================
// Module      : dpram_hs_pkg
// Description : Shared constants and request record for the dpram_hs block.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package dpram_hs_pkg;

    localparam int RESP_DEPTH   = 2;
    localparam int CNT_W        = $clog2(RESP_DEPTH + 1);

    // Request record fields are sized for the widest supported configuration.
    localparam int REQ_ADDR_MAX = 16;
    localparam int REQ_DATA_MAX = 64;

    typedef struct packed {
        logic                    we;
        logic [REQ_ADDR_MAX-1:0] addr;
        logic [REQ_DATA_MAX-1:0] data;
    } dpram_req_t;

endpackage : dpram_hs_pkg

`default_nettype wire

// File: rtl/dpram_hs_resp_fifo.sv
// =============================================================================
// Module      : dpram_hs_resp_fifo
// Description : Two-entry response FIFO; head is always presented on head_o.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module dpram_hs_resp_fifo
    import dpram_hs_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [CNT_W-1:0]  count_o,
    output logic [DATA_W-1:0] head_o
);

    logic [DATA_W-1:0] entry0_q, entry0_d;
    logic [DATA_W-1:0] entry1_q, entry1_d;
    logic [CNT_W-1:0]  count_q,  count_d;

    // The caller never pushes when full and never pops when empty.
    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        count_d  = count_q;
        unique case ({push_i, pop_i})
            2'b10: begin
                if (count_q == '0) begin
                    entry0_d = data_i;
                end else begin
                    entry1_d = data_i;
                end
                count_d = count_q + CNT_W'(1);
            end
            2'b01: begin
                entry0_d = entry1_q;
                count_d  = count_q - CNT_W'(1);
            end
            2'b11: begin
                if (count_q == CNT_W'(1)) begin
                    entry0_d = data_i;
                end else begin
                    entry0_d = entry1_q;
                    entry1_d = data_i;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry0_q <= '0;
            entry1_q <= '0;
            count_q  <= '0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            count_q  <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = entry0_q;

endmodule : dpram_hs_resp_fifo

`default_nettype wire

// File: rtl/dpram_hs.sv
// =============================================================================
// Module      : dpram_hs
// Description : Dual-port read-first RAM with valid/ready request and response
//               handshakes; optional collision pulse via DPRAM_HS_COLLISION_EN.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module dpram_hs
    import dpram_hs_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_a,
    output logic              ready_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] data_a,
    output logic              rvalid_a,
    input  logic              rready_a,
    output logic [DATA_W-1:0] q_a,
    input  logic              valid_b,
    output logic              ready_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] data_b,
    output logic              rvalid_b,
    input  logic              rready_b,
    output logic [DATA_W-1:0] q_b
`ifdef DPRAM_HS_COLLISION_EN
    ,
    output logic              collision
`endif
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [0:DEPTH-1];

    dpram_req_t        w_req_a, w_req_b;
    logic [ADDR_W-1:0] w_idx_a, w_idx_b;
    logic [DATA_W-1:0] w_wdata_a, w_wdata_b;
    logic [DATA_W-1:0] w_resp_a, w_resp_b;
    logic              w_acc_a, w_acc_b;
    logic              w_wr_a, w_wr_b;
    logic [CNT_W-1:0]  w_cnt_a, w_cnt_b;
    logic [DATA_W-1:0] w_head_a, w_head_b;

    always_comb begin
        w_req_a      = '0;
        w_req_a.we   = we_a;
        w_req_a.addr = REQ_ADDR_MAX'(addr_a);
        w_req_a.data = REQ_DATA_MAX'(data_a);
        w_req_b      = '0;
        w_req_b.we   = we_b;
        w_req_b.addr = REQ_ADDR_MAX'(addr_b);
        w_req_b.data = REQ_DATA_MAX'(data_b);
    end

    assign w_idx_a   = w_req_a.addr[ADDR_W-1:0];
    assign w_idx_b   = w_req_b.addr[ADDR_W-1:0];
    assign w_wdata_a = w_req_a.data[DATA_W-1:0];
    assign w_wdata_b = w_req_b.data[DATA_W-1:0];

    // Zero padding above the configured widths carries no information.
    generate
        if (ADDR_W < REQ_ADDR_MAX) begin : g_addr_pad
            logic w_unused_addr;
            assign w_unused_addr = ^{w_req_a.addr[REQ_ADDR_MAX-1:ADDR_W],
                                     w_req_b.addr[REQ_ADDR_MAX-1:ADDR_W]};
        end
        if (DATA_W < REQ_DATA_MAX) begin : g_data_pad
            logic w_unused_data;
            assign w_unused_data = ^{w_req_a.data[REQ_DATA_MAX-1:DATA_W],
                                     w_req_b.data[REQ_DATA_MAX-1:DATA_W]};
        end
    endgenerate

    assign ready_a  = (w_cnt_a < CNT_W'(RESP_DEPTH)) & ~rst;
    assign ready_b  = (w_cnt_b < CNT_W'(RESP_DEPTH)) & ~rst;
    assign w_acc_a  = valid_a & ready_a;
    assign w_acc_b  = valid_b & ready_b;
    assign w_wr_a   = w_acc_a & w_req_a.we;
    assign w_wr_b   = w_acc_b & w_req_b.we;

    // Reads see pre-edge contents because the array updates non-blocking.
    assign w_resp_a = w_req_a.we ? w_wdata_a : mem_q[w_idx_a];
    assign w_resp_b = w_req_b.we ? w_wdata_b : mem_q[w_idx_b];

    // Port A is written last so it wins a same-address write-write collision.
    always_ff @(posedge clk) begin
        if (w_wr_b) begin
            mem_q[w_idx_b] <= w_wdata_b;
        end
        if (w_wr_a) begin
            mem_q[w_idx_a] <= w_wdata_a;
        end
    end

    dpram_hs_resp_fifo #(.DATA_W(DATA_W)) u_fifo_a (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_acc_a),
        .data_i  (w_resp_a),
        .pop_i   (rvalid_a & rready_a),
        .count_o (w_cnt_a),
        .head_o  (w_head_a)
    );

    dpram_hs_resp_fifo #(.DATA_W(DATA_W)) u_fifo_b (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_acc_b),
        .data_i  (w_resp_b),
        .pop_i   (rvalid_b & rready_b),
        .count_o (w_cnt_b),
        .head_o  (w_head_b)
    );

    assign rvalid_a = (w_cnt_a != '0) & ~rst;
    assign rvalid_b = (w_cnt_b != '0) & ~rst;
    assign q_a      = rst ? '0 : w_head_a;
    assign q_b      = rst ? '0 : w_head_b;

`ifdef DPRAM_HS_COLLISION_EN
    logic collision_q, collision_d;

    always_comb begin
        collision_d = w_acc_a & w_acc_b & (w_req_a.addr == w_req_b.addr)
                    & (w_req_a.we | w_req_b.we);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            collision_q <= 1'b0;
        end else begin
            collision_q <= collision_d;
        end
    end

    assign collision = collision_q & ~rst;
`endif

endmodule : dpram_hs

`default_nettype wire

// File: tb/tb_dpram_hs.sv
// =============================================================================
// Module      : tb_dpram_hs
// Description : Self-checking bench for dpram_hs (default and 16/10 widths).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_dpram_hs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       valid_a, ready_a, we_a, rvalid_a, rready_a;
    logic [5:0] addr_a;
    logic [7:0] data_a, q_a;
    logic       valid_b, ready_b, we_b, rvalid_b, rready_b;
    logic [5:0] addr_b;
    logic [7:0] data_b, q_b;
`ifdef DPRAM_HS_COLLISION_EN
    logic       collision, collision2;
`endif

    logic        v2, rdy2, w2, rv2;
    logic [9:0]  a2;
    logic [15:0] d2, q2;
    logic        rdy2_b, rv2_b;
    logic [15:0] q2_b;

    dpram_hs dut (
        .clk(clk), .rst(rst),
        .valid_a(valid_a), .ready_a(ready_a), .we_a(we_a), .addr_a(addr_a),
        .data_a(data_a), .rvalid_a(rvalid_a), .rready_a(rready_a), .q_a(q_a),
        .valid_b(valid_b), .ready_b(ready_b), .we_b(we_b), .addr_b(addr_b),
        .data_b(data_b), .rvalid_b(rvalid_b), .rready_b(rready_b), .q_b(q_b)
`ifdef DPRAM_HS_COLLISION_EN
        , .collision(collision)
`endif
    );

    dpram_hs #(.DATA_W(16), .ADDR_W(10)) dut2 (
        .clk(clk), .rst(rst),
        .valid_a(v2), .ready_a(rdy2), .we_a(w2), .addr_a(a2),
        .data_a(d2), .rvalid_a(rv2), .rready_a(1'b1), .q_a(q2),
        .valid_b(1'b0), .ready_b(rdy2_b), .we_b(1'b0), .addr_b(10'd0),
        .data_b(16'd0), .rvalid_b(rv2_b), .rready_b(1'b1), .q_b(q2_b)
`ifdef DPRAM_HS_COLLISION_EN
        , .collision(collision2)
`endif
    );

    typedef struct {
        logic       va, wa;
        logic [5:0] aa;
        logic [7:0] da;
        logic       vb, wb;
        logic [5:0] ab;
        logic [7:0] db;
        logic       e_rva;
        logic [7:0] e_qa;
        logic       e_rvb;
        logic [7:0] e_qb;
        logic       e_coll;
    } vec_t;

    vec_t tbl [10];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: memory image and per-port queues of pending responses.
    logic [7:0] mem [64];
    logic [7:0] qa [$];
    logic [7:0] qb [$];
    logic [7:0] pop_log [$];
    bit         exp_coll;
    bit         acc_a_last;
    bit         log_en, tbl_en;
    int         tbl_idx;
    logic       last_ready_a, last_rvalid_a, last_rvalid_b;
    logic [7:0] last_q_a;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        logic [7:0] resp_a, resp_b;
        bit acc_a, acc_b, pop_a, pop_b;
        @(negedge clk);
        chk("ready_a", 64'(ready_a), 64'(!rst && qa.size() < 2));
        chk("ready_b", 64'(ready_b), 64'(!rst && qb.size() < 2));
        chk("rvalid_a", 64'(rvalid_a), 64'(!rst && qa.size() > 0));
        chk("rvalid_b", 64'(rvalid_b), 64'(!rst && qb.size() > 0));
        if (rst) begin
            chk("q_a_in_reset", 64'(q_a), 64'd0);
            chk("q_b_in_reset", 64'(q_b), 64'd0);
        end else begin
            if (qa.size() > 0) chk("q_a", 64'(q_a), 64'(qa[0]));
            if (qb.size() > 0) chk("q_b", 64'(q_b), 64'(qb[0]));
        end
`ifdef DPRAM_HS_COLLISION_EN
        chk("collision", 64'(collision), 64'(!rst && exp_coll));
`endif
        last_ready_a  = ready_a;
        last_rvalid_a = rvalid_a;
        last_rvalid_b = rvalid_b;
        last_q_a      = q_a;
        if (log_en && rvalid_a && rready_a) pop_log.push_back(q_a);
        if (tbl_en) begin
            chk("tbl_rvalid_a", 64'(rvalid_a), 64'(tbl[tbl_idx].e_rva));
            chk("tbl_rvalid_b", 64'(rvalid_b), 64'(tbl[tbl_idx].e_rvb));
            if (tbl[tbl_idx].e_rva) chk("tbl_q_a", 64'(q_a), 64'(tbl[tbl_idx].e_qa));
            if (tbl[tbl_idx].e_rvb) chk("tbl_q_b", 64'(q_b), 64'(tbl[tbl_idx].e_qb));
`ifdef DPRAM_HS_COLLISION_EN
            chk("tbl_collision", 64'(collision), 64'(tbl[tbl_idx].e_coll));
`endif
        end
        @(posedge clk);
        acc_a    = 1'b0;
        acc_b    = 1'b0;
        exp_coll = 1'b0;
        if (rst) begin
            qa.delete();
            qb.delete();
        end else begin
            acc_a  = valid_a && qa.size() < 2;
            acc_b  = valid_b && qb.size() < 2;
            pop_a  = qa.size() > 0 && rready_a;
            pop_b  = qb.size() > 0 && rready_b;
            resp_a = we_a ? data_a : mem[addr_a];
            resp_b = we_b ? data_b : mem[addr_b];
            exp_coll = acc_a && acc_b && addr_a == addr_b && (we_a || we_b);
            if (pop_a) void'(qa.pop_front());
            if (pop_b) void'(qb.pop_front());
            if (acc_a) qa.push_back(resp_a);
            if (acc_b) qb.push_back(resp_b);
            if (acc_b && we_b) mem[addr_b] = data_b;
            if (acc_a && we_a) mem[addr_a] = data_a;
        end
        acc_a_last = acc_a;
        #1;
    endtask

    task automatic idle_inputs();
        valid_a = 0; we_a = 0; addr_a = 0; data_a = 0; rready_a = 1;
        valid_b = 0; we_b = 0; addr_b = 0; data_b = 0; rready_b = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] seq_addr [3];
        logic [7:0] seq_want [3];
        int k;

        rst = 1; idle_inputs();
        v2 = 0; w2 = 0; a2 = 0; d2 = 0;
        exp_coll = 0; log_en = 0; tbl_en = 0; tbl_idx = 0;
        tick(); tick();
        rst = 0;

        // Fill every word so later reads never depend on power-up contents.
        for (int i = 0; i < 64; i++) begin
            valid_a = 1; we_a = 1; addr_a = 6'(i); data_a = 8'($urandom);
            tick();
        end
        idle_inputs();
        tick();

        tbl[0] = '{1,1,6'd5,8'h3C, 0,0,6'd0,8'h00, 0,8'h00, 0,8'h00, 0};
        tbl[1] = '{0,0,6'd0,8'h00, 1,0,6'd5,8'h00, 1,8'h3C, 0,8'h00, 0};
        tbl[2] = '{1,1,6'd9,8'h11, 1,1,6'd9,8'h22, 0,8'h00, 1,8'h3C, 0};
        tbl[3] = '{0,0,6'd0,8'h00, 0,0,6'd0,8'h00, 1,8'h11, 1,8'h22, 1};
        tbl[4] = '{1,1,6'd7,8'hAA, 0,0,6'd0,8'h00, 0,8'h00, 0,8'h00, 0};
        tbl[5] = '{1,0,6'd7,8'h00, 1,1,6'd7,8'h55, 1,8'hAA, 0,8'h00, 0};
        tbl[6] = '{1,0,6'd7,8'h00, 1,0,6'd9,8'h00, 1,8'hAA, 1,8'h55, 1};
        tbl[7] = '{1,0,6'd9,8'h00, 1,0,6'd9,8'h00, 1,8'h55, 1,8'h11, 0};
        tbl[8] = '{0,0,6'd0,8'h00, 0,0,6'd0,8'h00, 1,8'h11, 1,8'h11, 0};
        tbl[9] = '{0,0,6'd0,8'h00, 0,0,6'd0,8'h00, 0,8'h00, 0,8'h00, 0};

        tbl_en = 1;
        for (int i = 0; i < 10; i++) begin
            tbl_idx = i;
            valid_a = tbl[i].va; we_a = tbl[i].wa; addr_a = tbl[i].aa; data_a = tbl[i].da;
            valid_b = tbl[i].vb; we_b = tbl[i].wb; addr_b = tbl[i].ab; data_b = tbl[i].db;
            tick();
        end
        tbl_en = 0;
        idle_inputs();

        // Backpressure: three reads on A with the consumer stalled.
        seq_addr = '{6'd5, 6'd9, 6'd7};
        seq_want = '{8'h3C, 8'h11, 8'h55};
        k = 0;
        pop_log.delete();
        log_en = 1;
        for (int c = 0; c < 20 && (k < 3 || pop_log.size() < 3); c++) begin
            rready_a = (c >= 4);
            valid_a  = (k < 3);
            we_a     = 0;
            addr_a   = seq_addr[(k > 2) ? 2 : k];
            tick();
            if (c == 2) chk("bp_ready_a_low", 64'(last_ready_a), 64'd0);
            if (acc_a_last) k++;
        end
        log_en = 0;
        chk("bp_accepts", 64'(k), 64'd3);
        chk("bp_responses", 64'(pop_log.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < pop_log.size()) chk("bp_order", 64'(pop_log[i]), 64'(seq_want[i]));
        end
        idle_inputs();
        tick();

        // Reset with responses buffered on both ports.
        rready_a = 0; rready_b = 0;
        valid_a = 1; addr_a = 6'd1; valid_b = 1; addr_b = 6'd2;
        tick();
        addr_a = 6'd3; addr_b = 6'd4;
        tick();
        valid_a = 0; valid_b = 0; rst = 1;
        tick();
        chk("rst_rvalid_a", 64'(last_rvalid_a), 64'd0);
        chk("rst_rvalid_b", 64'(last_rvalid_b), 64'd0);
        chk("rst_ready_a", 64'(last_ready_a), 64'd0);
        rst = 0; rready_a = 1; rready_b = 1;
        valid_a = 1; we_a = 0; addr_a = 6'd5;
        tick();
        chk("post_rst_ready_a", 64'(last_ready_a), 64'd1);
        valid_a = 0;
        tick();
        chk("retain_rvalid_a", 64'(last_rvalid_a), 64'd1);
        chk("retain_q_a", 64'(last_q_a), 64'h3C);

        // Randomized traffic on a narrow address window to force collisions.
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 59) == 0);
            valid_a  = 1'($urandom_range(0, 1));
            we_a     = 1'($urandom_range(0, 1));
            addr_a   = 6'($urandom_range(0, 7));
            data_a   = 8'($urandom);
            rready_a = ($urandom_range(0, 3) != 0);
            valid_b  = 1'($urandom_range(0, 1));
            we_b     = 1'($urandom_range(0, 1));
            addr_b   = 6'($urandom_range(0, 7));
            data_b   = 8'($urandom);
            rready_b = ($urandom_range(0, 3) != 0);
            tick();
        end
        rst = 0;
        idle_inputs();
        for (int i = 0; i < 4; i++) tick();

        // Wide configuration: top address must not alias address 0.
        @(posedge clk); #1;
        v2 = 1; w2 = 1; a2 = 10'd1023; d2 = 16'hBEEF;
        @(posedge clk); #1;
        a2 = 10'd0; d2 = 16'h1234;
        @(negedge clk);
        chk("w16_echo_rvalid", 64'(rv2), 64'd1);
        chk("w16_echo_q", 64'(q2), 64'hBEEF);
        @(posedge clk); #1;
        w2 = 0; a2 = 10'd1023;
        @(negedge clk);
        chk("w16_echo0_q", 64'(q2), 64'h1234);
        @(posedge clk); #1;
        a2 = 10'd0;
        @(negedge clk);
        chk("w16_read_top", 64'(q2), 64'hBEEF);
        @(posedge clk); #1;
        v2 = 0;
        @(negedge clk);
        chk("w16_read_zero", 64'(q2), 64'h1234);
        chk("w16_rvalid", 64'(rv2), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_dpram_hs

`default_nettype wire
